// File: rtl/cipher_ctrl.sv
// rtl/cipher_ctrl.sv - AES-128 round and key-expansion sequencer
// One job at a time; decrypt first walks the expander forward, then runs rounds with predone.
module cipher_ctrl #(
   parameter int NR = 10,
   parameter int RW = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start_valid,
   output logic          start_ready,
   input  logic          decrypt,
   output logic          ld_en,
   output logic          exp_reset,
   output logic          exp_predone,
   output logic          dec_mode,
   output logic          state_en,
   output logic [RW-1:0] round,
   output logic          first_round,
   output logic          last_round,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          busy
);
   typedef enum logic [1:0] {IDLE, FWD, RUN, DONE} state_t;

   localparam logic [RW-1:0] CNT_RUN_LAST = RW'(NR);
   localparam logic [RW-1:0] CNT_FWD_LAST = RW'(NR - 1);

   state_t        state;
   state_t        nxt_state;
   logic [RW-1:0] cnt;
   logic [RW-1:0] nxt_cnt;
   logic          nxt_dec;

   always_comb begin
      nxt_state = state;
      nxt_cnt   = cnt;
      nxt_dec   = dec_mode;
      case (state)
         IDLE: begin
            if (start_valid) begin
               nxt_dec   = decrypt;
               nxt_cnt   = '0;
               nxt_state = decrypt ? FWD : RUN;
            end
         end
         FWD: begin
            if (cnt == CNT_FWD_LAST) begin
               nxt_cnt   = '0;
               nxt_state = RUN;
            end else begin
               nxt_cnt = cnt + RW'(1);
            end
         end
         RUN: begin
            if (cnt == CNT_RUN_LAST) begin
               nxt_cnt   = '0;
               nxt_state = DONE;
            end else begin
               nxt_cnt = cnt + RW'(1);
            end
         end
         DONE: begin
            if (out_ready) nxt_state = IDLE;
         end
         default: nxt_state = IDLE;
      endcase
   end

   // Outputs are registered from the next-state values so only ld_en sees start_valid combinationally.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         dec_mode    <= 1'b0;
         start_ready <= 1'b1;
         busy        <= 1'b0;
         state_en    <= 1'b0;
         round       <= '0;
         first_round <= 1'b0;
         last_round  <= 1'b0;
         exp_predone <= 1'b0;
         out_valid   <= 1'b0;
      end else begin
         state       <= nxt_state;
         cnt         <= nxt_cnt;
         dec_mode    <= nxt_dec;
         start_ready <= (nxt_state == IDLE);
         busy        <= (nxt_state != IDLE);
         state_en    <= (nxt_state == RUN);
         round       <= (nxt_state == RUN) ? nxt_cnt : '0;
         first_round <= (nxt_state == RUN) && (nxt_cnt == '0);
         last_round  <= (nxt_state == RUN) && (nxt_cnt == CNT_RUN_LAST);
         exp_predone <= (nxt_state == RUN) && nxt_dec;
         out_valid   <= (nxt_state == DONE);
      end
   end

   assign ld_en     = start_valid & start_ready;
   assign exp_reset = reset | start_ready;

endmodule

// File: tb/tb_cipher_ctrl.sv
// tb/tb_cipher_ctrl.sv - bench for cipher_ctrl
// Job-level model (cycles since accept) plus a round-key index model of the expander.
module tb_cipher_ctrl;
   localparam int NR = 10;
   localparam int RW = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start_valid = 1'b0;
   logic          decrypt = 1'b0;
   logic          out_ready = 1'b0;
   logic          start_ready, ld_en, exp_reset, exp_predone, dec_mode, state_en;
   logic [RW-1:0] round;
   logic          first_round, last_round, out_valid, busy;

   cipher_ctrl #(.NR(NR), .RW(RW)) dut (
      .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(start_ready),
      .decrypt(decrypt), .ld_en(ld_en), .exp_reset(exp_reset), .exp_predone(exp_predone),
      .dec_mode(dec_mode), .state_en(state_en), .round(round), .first_round(first_round),
      .last_round(last_round), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   bit mon_en = 1'b0;
   bit m_busy = 1'b0;
   bit m_dec = 1'b0;
   int m_k = 0;
   int idx = 0;
   int idx_pend = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Cycles spent in FWD+RUN before the result is held.
   function automatic int job_len(input bit dec);
      return dec ? 2 * NR + 1 : NR + 1;
   endfunction

   always @(posedge clk) begin
      idx = idx_pend;
      if (reset) begin
         m_busy = 1'b0;
         m_dec  = 1'b0;
         m_k    = 0;
      end else if (!m_busy) begin
         if (start_valid) begin
            m_busy = 1'b1;
            m_dec  = decrypt;
            m_k    = 1;
         end
      end else if (m_k > job_len(m_dec)) begin
         if (out_ready) m_busy = 1'b0;
      end else begin
         m_k++;
      end
   end

   always @(negedge clk) begin : mon
      logic        done, fwd, run;
      int          r;
      logic [13:0] e, a;
      if (mon_en) begin
         done = m_busy && (m_k > job_len(m_dec));
         fwd  = m_busy && m_dec && (m_k <= NR);
         run  = m_busy && !done && !fwd;
         r    = !run ? 0 : (m_dec ? m_k - NR - 1 : m_k - 1);
         e = {!m_busy, start_valid && !m_busy, reset || !m_busy, run && m_dec, m_dec, run,
              4'(r), run && (r == 0), run && (r == NR), done, m_busy};
         a = {start_ready, ld_en, exp_reset, exp_predone, dec_mode, state_en,
              round, first_round, last_round, out_valid, busy};
         chk("outputs", 32'(a), 32'(e));
         if (run) chk("rk_index", 32'(idx), 32'(m_dec ? NR - r : r));
      end
      idx_pend = exp_reset ? 0 : (exp_predone ? idx - 1 : idx + 1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_job(input bit dec, input int stall, input bit noise, input int exp_lat);
      int n;
      bit acc;
      start_valid = 1'b1;
      decrypt     = dec;
      out_ready   = 1'b0;
      acc = 1'b0;
      for (int i = 0; i < 4 && !acc; i++) begin
         step();
         acc = m_busy;
      end
      chk("accept", 32'(acc), 32'd1);
      start_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 60) begin
         if (noise) begin
            start_valid = 1'($urandom_range(0, 1));
            decrypt     = 1'($urandom_range(0, 1));
            out_ready   = 1'($urandom_range(0, 1));
         end
         step();
         n++;
      end
      start_valid = 1'b0;
      out_ready   = 1'b0;
      chk("latency", 32'(n), 32'(exp_lat));
      for (int i = 0; i < stall; i++) begin
         step();
         chk("hold_valid", 32'(out_valid), 32'd1);
         chk("hold_ready", 32'(start_ready), 32'd0);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("back_idle", 32'(busy), 32'd0);
   endtask

   typedef struct {
      bit dec;
      int stall;
      bit noise;
      int lat;
   } vec_t;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[6];
      int   n;
      bit   found;
      vecs = '{'{0, 0, 0, 12}, '{1, 0, 0, 22}, '{0, 5, 0, 12},
               '{1, 2, 1, 22}, '{0, 1, 1, 12}, '{1, 5, 0, 22}};

      @(posedge clk);
      #1;
      mon_en = 1'b1;
      step();
      chk("rst_start_ready", 32'(start_ready), 32'd1);
      chk("rst_exp_reset", 32'(exp_reset), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_state_en", 32'(state_en), 32'd0);
      chk("rst_dec_mode", 32'(dec_mode), 32'd0);
      reset = 1'b0;
      step();

      foreach (vecs[i]) run_job(vecs[i].dec, vecs[i].stall, vecs[i].noise, vecs[i].lat);

      // Back-to-back: start held high through the result handshake.
      start_valid = 1'b1;
      decrypt     = 1'b0;
      step();
      start_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 60) begin
         step();
         n++;
      end
      chk("b2b_first_lat", 32'(n), 32'd12);
      out_ready   = 1'b1;
      start_valid = 1'b1;
      decrypt     = 1'b1;
      step();
      out_ready = 1'b0;
      chk("b2b_idle", 32'(start_ready), 32'd1);
      chk("b2b_ld_en", 32'(ld_en), 32'd1);
      step();
      start_valid = 1'b0;
      chk("b2b_accept", 32'(busy), 32'd1);
      n = 1;
      while (!out_valid && n < 60) begin
         step();
         n++;
      end
      chk("b2b_second_lat", 32'(n), 32'd22);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;

      // Reset pulsed during decrypt round 4.
      start_valid = 1'b1;
      decrypt     = 1'b1;
      step();
      start_valid = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         if (round == 4'd4 && exp_predone) found = 1'b1;
         else step();
      end
      chk("mid_reset_reach_r4", 32'(found), 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mid_reset_busy", 32'(busy), 32'd0);
      chk("mid_reset_exp_reset", 32'(exp_reset), 32'd1);
      chk("mid_reset_out_valid", 32'(out_valid), 32'd0);
      chk("mid_reset_dec_mode", 32'(dec_mode), 32'd0);
      run_job(1'b0, 0, 1'b0, 12);

      for (int j = 0; j < 400; j++) begin
         bit d;
         d = 1'($urandom_range(0, 1));
         run_job(d, int'($urandom_range(0, 3)), 1'b1, d ? 2 * NR + 2 : NR + 2);
         repeat ($urandom_range(0, 2)) step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
